// File: rtl/imm_dispatch_if.sv
//----------------------------------------------------------------------
// imm_dispatch_if : handshake/bus bundle for the immediate dispatcher
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface imm_dispatch_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_imm;
  logic [2:0]       out_fmt;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, illegal_cnt
  );

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, illegal_cnt
  );
endinterface

`default_nettype wire

// File: rtl/imm_dispatch.sv
//----------------------------------------------------------------------
// imm_dispatch : RV32I immediate classifier with 2-entry output buffer
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module imm_dispatch #(
  parameter int CNT_W = 16
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  imm_dispatch_if.slave bus
);
  localparam logic [2:0] c_FMT_NONE    = 3'd0;
  localparam logic [2:0] c_FMT_I       = 3'd1;
  localparam logic [2:0] c_FMT_S       = 3'd2;
  localparam logic [2:0] c_FMT_B       = 3'd3;
  localparam logic [2:0] c_FMT_U       = 3'd4;
  localparam logic [2:0] c_FMT_J       = 3'd5;
  localparam logic [2:0] c_FMT_CSR     = 3'd6;
  localparam logic [2:0] c_FMT_ILLEGAL = 3'd7;

  logic [31:0]      w_instr;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [2:0]       w_fmt;
  logic [31:0]      w_imm;
  logic             w_push;
  logic             w_pop;

  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [2:0]       r_mem_fmt [2];
  logic [31:0]      r_mem_imm [2];
  logic [2:0]       r_head_fmt;
  logic [31:0]      r_head_imm;
  logic [CNT_W-1:0] r_illegal_cnt;

  assign w_instr  = bus.in_instr;
  assign w_opcode = w_instr[6:0];
  assign w_funct3 = w_instr[14:12];

  // Immediates are zero-filled; sign handling is left to the consumer.
  always_comb begin
    w_fmt = c_FMT_ILLEGAL;
    w_imm = 32'd0;
    case (w_opcode)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        w_fmt = c_FMT_I;
        w_imm = {20'b0, w_instr[31:20]};
      end
      7'b0100011: begin
        w_fmt = c_FMT_S;
        w_imm = {20'b0, w_instr[31:25], w_instr[11:7]};
      end
      7'b1100011: begin
        w_fmt = c_FMT_B;
        w_imm = {19'b0, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_fmt = c_FMT_U;
        w_imm = {w_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        w_fmt = c_FMT_J;
        w_imm = {11'b0, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
      end
      7'b1110011: begin
        case (w_funct3)
          3'b101, 3'b110, 3'b111: begin
            w_fmt = c_FMT_CSR;
            w_imm = {27'b0, w_instr[19:15]};
          end
          3'b001, 3'b010, 3'b011: begin
            w_fmt = c_FMT_I;
            w_imm = {20'b0, w_instr[31:20]};
          end
          3'b000:  w_fmt = c_FMT_NONE;
          default: w_fmt = c_FMT_ILLEGAL;
        endcase
      end
      7'b0110011: w_fmt = c_FMT_NONE;
      default:    w_fmt = c_FMT_ILLEGAL;
    endcase
  end

  // Ready is derived only from registered occupancy, so a pop from full
  // does not admit a new word in the same cycle.
  assign bus.in_ready  = (r_count != 2'd2) && !bus.flush;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_imm   = r_head_imm;
  assign bus.out_fmt   = r_head_fmt;
  assign bus.illegal_cnt = r_illegal_cnt;

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_mem_fmt[0] <= 3'd0;
      r_mem_fmt[1] <= 3'd0;
      r_mem_imm[0] <= 32'd0;
      r_mem_imm[1] <= 32'd0;
      r_head_fmt   <= 3'd0;
      r_head_imm   <= 32'd0;
    end else if (bus.flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_fmt[r_wr_ptr] <= w_fmt;
        r_mem_imm[r_wr_ptr] <= w_imm;
        r_wr_ptr            <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      // Head register tracks the oldest entry; it holds when the buffer drains.
      if (w_pop) begin
        if (r_count == 2'd2) begin
          r_head_fmt <= r_mem_fmt[~r_rd_ptr];
          r_head_imm <= r_mem_imm[~r_rd_ptr];
        end else if (w_push) begin
          r_head_fmt <= w_fmt;
          r_head_imm <= w_imm;
        end
      end else if (w_push && (r_count == 2'd0)) begin
        r_head_fmt <= w_fmt;
        r_head_imm <= w_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_push && (w_fmt == c_FMT_ILLEGAL) && (r_illegal_cnt != '1)) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_imm_dispatch.sv
//----------------------------------------------------------------------
// tb_imm_dispatch : vector table, corner sequences and random traffic
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_imm_dispatch;
  logic clk;
  logic rst_n;

  imm_dispatch_if #(.CNT_W(16)) ifa ();
  imm_dispatch_if #(.CNT_W(2))  ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_instr  = ifa.in_instr;
  assign ifb.flush     = ifa.flush;
  assign ifb.out_ready = ifa.out_ready;

  imm_dispatch #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
  imm_dispatch #(.CNT_W(2))  u_dut_small (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
  } entry_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } vec_t;

  entry_t      q[$];
  int unsigned ill_total;
  int          n_cmp;
  int          n_fail;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the format rules using shifts and masks.
  function automatic entry_t ref_decode(input logic [31:0] w);
    entry_t      e;
    int unsigned u;
    int unsigned opc;
    int unsigned f3;
    u   = w;
    opc = u & 32'h7f;
    f3  = (u >> 12) & 7;
    e.fmt = 3'd7;
    e.imm = 32'd0;
    case (opc)
      32'h03, 32'h13, 32'h67: begin e.fmt = 3'd1; e.imm = u >> 20; end
      32'h23: begin e.fmt = 3'd2; e.imm = ((u >> 25) << 5) | ((u >> 7) & 32'h1f); end
      32'h63: begin
        e.fmt = 3'd3;
        e.imm = ((u >> 31) << 12) | (((u >> 7) & 1) << 11) |
                (((u >> 25) & 32'h3f) << 5) | (((u >> 8) & 32'hf) << 1);
      end
      32'h37, 32'h17: begin e.fmt = 3'd4; e.imm = u & 32'hfffff000; end
      32'h6f: begin
        e.fmt = 3'd5;
        e.imm = ((u >> 31) << 20) | (((u >> 12) & 32'hff) << 12) |
                (((u >> 20) & 1) << 11) | (((u >> 21) & 32'h3ff) << 1);
      end
      32'h73: begin
        if (f3 >= 5) begin e.fmt = 3'd6; e.imm = (u >> 15) & 32'h1f; end
        else if (f3 >= 1 && f3 <= 3) begin e.fmt = 3'd1; e.imm = u >> 20; end
        else if (f3 == 0) e.fmt = 3'd0;
      end
      32'h33: e.fmt = 3'd0;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // One cycle: drive at negedge, check ready, clock, update model, check outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic ordy);
    logic push;
    logic pop;
    entry_t e;
    ifa.in_valid  = v;
    ifa.in_instr  = ins;
    ifa.flush     = fl;
    ifa.out_ready = ordy;
    #1;
    cmp("in_ready", {31'b0, ifa.in_ready}, {31'b0, (q.size() < 2) && !fl});
    push = v && (q.size() < 2) && !fl;
    pop  = (q.size() > 0) && ordy;
    e    = ref_decode(ins);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        if (e.fmt == 3'd7) ill_total++;
      end
    end
    cmp("out_valid", {31'b0, ifa.out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      cmp("out_fmt", {29'b0, ifa.out_fmt}, {29'b0, q[0].fmt});
      cmp("out_imm", ifa.out_imm, q[0].imm);
    end
    cmp("illegal_cnt16", {16'b0, ifa.illegal_cnt}, sat(ill_total, 32'hffff));
    cmp("illegal_cnt2", {30'b0, ifb.illegal_cnt}, sat(ill_total, 3));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_instr  = 32'd0;
    ifa.flush     = 1'b0;
    ifa.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ill_total = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_in_ready"}, {31'b0, ifa.in_ready}, 32'd1);
    cmp({tag, "_out_valid"}, {31'b0, ifa.out_valid}, 32'd0);
    cmp({tag, "_out_imm"}, ifa.out_imm, 32'd0);
    cmp({tag, "_out_fmt"}, {29'b0, ifa.out_fmt}, 32'd0);
    cmp({tag, "_illegal_cnt"}, {16'b0, ifa.illegal_cnt}, 32'd0);
  endtask

  vec_t vecs[12];
  logic [6:0] ops[11];

  initial begin
    n_cmp = 0;
    n_fail = 0;
    ill_total = 0;
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'h00000FFF};
    vecs[1]  = '{32'hFE112E23, 3'd2, 32'h00000FFC};
    vecs[2]  = '{32'hFE000EE3, 3'd3, 32'h00001FFC};
    vecs[3]  = '{32'h123452B7, 3'd4, 32'h12345000};
    vecs[4]  = '{32'hFF9FF06F, 3'd5, 32'h001FFFF8};
    vecs[5]  = '{32'h3002D073, 3'd6, 32'h00000005};
    vecs[6]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000};
    vecs[7]  = '{32'h00000073, 3'd0, 32'h00000000};
    vecs[8]  = '{32'h30029073, 3'd1, 32'h00000300};
    vecs[9]  = '{32'h0020C0B3, 3'd0, 32'h00000000};
    vecs[10] = '{32'hABC0C073, 3'd7, 32'h00000000};
    vecs[11] = '{32'h80000017, 3'd4, 32'h80000000};
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73, 7'h33, 7'h7f};

    do_reset();
    check_reset_outputs("reset");

    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].instr, 1'b0, 1'b0);
      cmp("vec_fmt", {29'b0, ifa.out_fmt}, {29'b0, vecs[i].fmt});
      cmp("vec_imm", ifa.out_imm, vecs[i].imm);
      step(1'b0, 32'd0, 1'b0, 1'b1);
    end

    // Backpressure: A and B fill the buffer, C waits.
    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 1'b0, 1'b0);
    cmp("bp_full_ready", {31'b0, ifa.in_ready}, 32'd0);
    cmp("bp_head_A", ifa.out_imm, 32'h00000001);
    step(1'b1, 32'h00300193, 1'b0, 1'b1);
    cmp("bp_head_B", ifa.out_imm, 32'h00000002);
    step(1'b1, 32'h00300193, 1'b0, 1'b1);
    cmp("bp_head_C", ifa.out_imm, 32'h00000003);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    cmp("bp_drained", {31'b0, ifa.out_valid}, 32'd0);

    // Saturation of the narrow counter.
    for (int i = 0; i < 5; i++) step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    cmp("sat_cnt2", {30'b0, ifb.illegal_cnt}, 32'd3);

    // Flush with two buffered words and a word offered at the same time.
    step(1'b1, 32'h00500293, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    cmp("flush_valid", {31'b0, ifa.out_valid}, 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    cmp("flush_dropped", {31'b0, ifa.out_valid}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom();
      step(($urandom_range(0, 3) != 0), {r[31:7], ops[$urandom_range(0, 10)]},
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset mid-stream.
    step(1'b1, 32'h123452B7, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ill_total = 0;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h00700393, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

`default_nettype wire
